// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit active-low hex display scan back-end
//
// Takes the scan counter's digit index and a 16-bit value (plus per-digit
// decimal points) over a valid/ready handshake. New values wait in a
// one-deep pending register and only become visible at a frame boundary
// (digit_sel stepping 3 -> 0), so a frame never mixes digits of two values.
// After every digit_sel change all anodes stay off for BLANK_CYCLES clocks
// to hide ghosting, and leading zeros can be suppressed.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   digit_sel   current digit index from the scan counter, 0 = rightmost
//   data_in     value to show, digit i = data_in[4i+3:4i]
//   dp_in       decimal point per digit, 1 = lit, captured with data_in
//   data_valid  data_in/dp_in valid this cycle
//   data_ready  a value can be accepted this cycle
//   lz_en       leading-zero suppression enable, used live
//   anodes_n    digit enables, active-low, one-hot-low or all-high
//   seg_n       segments {g,f,e,d,c,b,a}, active-low
//   dp_n        decimal point, active-low

module seg7_scan_driver #(
   parameter int unsigned BLANK_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  digit_sel,
   input  logic [15:0] data_in,
   input  logic [3:0]  dp_in,
   input  logic        data_valid,
   output logic        data_ready,
   input  logic        lz_en,
   output logic [3:0]  anodes_n,
   output logic [6:0]  seg_n,
   output logic        dp_n
);

   localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES);

   logic [1:0]  sel_q;
   logic [7:0]  blank_cnt;
   logic [7:0]  blank_nxt;
   logic        pend_full;
   logic [15:0] pend_data;
   logic [3:0]  pend_dp;
   logic [15:0] act_data;
   logic [3:0]  act_dp;

   logic        boundary;
   logic        change;
   logic        xfer;
   logic [3:0]  nib;
   logic        dp_bit;
   logic        higher_zero;
   logic [3:0]  anodes_nxt;
   logic [6:0]  seg_nxt;
   logic        dp_nxt;

   function automatic logic [6:0] hex_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign data_ready = ~pend_full & ~reset;

   always_comb begin
      boundary = (sel_q == 2'd3) && (digit_sel == 2'd0);
      change   = (digit_sel != sel_q);
      xfer     = data_valid & data_ready;

      if (change)
         blank_nxt = BLANK_LOAD;
      else if (blank_cnt != 8'd0)
         blank_nxt = blank_cnt - 8'd1;
      else
         blank_nxt = 8'd0;

      nib    = act_data[{digit_sel, 2'b00} +: 4];
      dp_bit = act_dp[digit_sel];

      // A digit is a leading zero when it and every digit to its left are 0.
      case (digit_sel)
         2'd3:    higher_zero = (act_data[15:12] == 4'h0);
         2'd2:    higher_zero = (act_data[15:8]  == 8'h00);
         2'd1:    higher_zero = (act_data[15:4]  == 12'h000);
         default: higher_zero = 1'b0;
      endcase
   end

   // Output decode uses the pre-update active value, so results lag inputs by one edge.
   always_comb begin
      anodes_nxt = 4'hF;
      seg_nxt    = 7'h7F;
      dp_nxt     = 1'b1;
      if (blank_nxt == 8'd0) begin
         if (lz_en && higher_zero) begin
            // A suppressed digit still lights if it carries the decimal point.
            if (dp_bit) begin
               anodes_nxt = ~(4'b0001 << digit_sel);
               dp_nxt     = 1'b0;
            end
         end else begin
            anodes_nxt = ~(4'b0001 << digit_sel);
            seg_nxt    = hex_decode(nib);
            dp_nxt     = ~dp_bit;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q     <= 2'd0;
         blank_cnt <= 8'd0;
         pend_full <= 1'b0;
         pend_data <= 16'h0000;
         pend_dp   <= 4'h0;
         act_data  <= 16'h0000;
         act_dp    <= 4'h0;
         anodes_n  <= 4'hF;
         seg_n     <= 7'h7F;
         dp_n      <= 1'b1;
      end else begin
         sel_q     <= digit_sel;
         blank_cnt <= blank_nxt;
         anodes_n  <= anodes_nxt;
         seg_n     <= seg_nxt;
         dp_n      <= dp_nxt;
         // data_ready is low whenever pend_full is set, so promotion and a
         // transfer can never coincide; a transfer on an empty boundary waits
         // for the next boundary.
         if (boundary && pend_full) begin
            act_data  <= pend_data;
            act_dp    <= pend_dp;
            pend_full <= 1'b0;
         end else if (xfer) begin
            pend_data <= data_in;
            pend_dp   <= dp_in;
            pend_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver

module tb_seg7_scan_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset      = 1'b1;
   logic [1:0]  digit_sel  = 2'd0;
   logic [15:0] data_in    = 16'h0000;
   logic [3:0]  dp_in      = 4'h0;
   logic        data_valid = 1'b0;
   logic        lz_en      = 1'b0;

   logic        rdy0, rdy1, dp0, dp1;
   logic [3:0]  an0, an1;
   logic [6:0]  sg0, sg1;

   seg7_scan_driver #(.BLANK_CYCLES(4)) u_blank4 (
      .clk(clk), .reset(reset), .digit_sel(digit_sel), .data_in(data_in),
      .dp_in(dp_in), .data_valid(data_valid), .data_ready(rdy0), .lz_en(lz_en),
      .anodes_n(an0), .seg_n(sg0), .dp_n(dp0));

   seg7_scan_driver #(.BLANK_CYCLES(0)) u_blank0 (
      .clk(clk), .reset(reset), .digit_sel(digit_sel), .data_in(data_in),
      .dp_in(dp_in), .data_valid(data_valid), .data_ready(rdy1), .lz_en(lz_en),
      .anodes_n(an1), .seg_n(sg1), .dp_n(dp1));

   typedef struct packed {
      logic [3:0] an0;
      logic [6:0] sg0;
      logic       dp0;
      logic       cs0;
      logic [3:0] an1;
      logic [6:0] sg1;
      logic       dp1;
      logic       cs1;
      logic       rdy;
   } exp_t;

   exp_t expq[$];
   int vectors = 0;
   int errors  = 0;

   int blank_len[2] = '{4, 0};
   logic [6:0] hex_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model: the shown value, a pending slot, and the time of the
   // most recent digit change; blanking is "fewer than N edges since change".
   int          cyc = 0;
   int          last_change = -100000;
   logic [15:0] m_act = 16'h0000;
   logic [3:0]  m_adp = 4'h0;
   logic [15:0] m_pend = 16'h0000;
   logic [3:0]  m_pdp = 4'h0;
   int          m_full = 0;
   int          m_prev = 0;

   task automatic expect_digit(input logic [15:0] v, input logic [3:0] dpv, input int d,
                               input logic lz, input logic blank,
                               output logic [3:0] an, output logic [6:0] sg,
                               output logic dpo, output logic cs);
      int upper;
      logic supp;
      upper = int'(v) / (1 << (4 * d));
      supp  = lz && (d > 0) && (upper == 0);
      an = 4'hF; sg = 7'h7F; dpo = 1'b1; cs = 1'b0;
      if (!blank) begin
         if (!supp) begin
            an = 4'hF ^ 4'(1 << d);
            sg = hex_tab[(int'(v) / (1 << (4 * d))) % 16];
            dpo = !dpv[d];
            cs = 1'b1;
         end else if (dpv[d]) begin
            an = 4'hF ^ 4'(1 << d);
            sg = 7'h7F;
            dpo = 1'b0;
            cs = 1'b1;
         end
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      logic b0, b1;
      if (reset) begin
         e = '{an0: 4'hF, sg0: 7'h7F, dp0: 1'b1, cs0: 1'b1,
               an1: 4'hF, sg1: 7'h7F, dp1: 1'b1, cs1: 1'b1, rdy: 1'b0};
         m_act = 16'h0000; m_adp = 4'h0; m_full = 0; m_prev = 0;
         last_change = -100000;
      end else begin
         if (int'(digit_sel) != m_prev) last_change = cyc;
         b0 = (cyc - last_change) < blank_len[0];
         b1 = (cyc - last_change) < blank_len[1];
         expect_digit(m_act, m_adp, int'(digit_sel), lz_en, b0, e.an0, e.sg0, e.dp0, e.cs0);
         expect_digit(m_act, m_adp, int'(digit_sel), lz_en, b1, e.an1, e.sg1, e.dp1, e.cs1);
         if (m_prev == 3 && digit_sel == 2'd0 && m_full != 0) begin
            m_act = m_pend; m_adp = m_pdp; m_full = 0;
         end else if (data_valid && m_full == 0) begin
            m_pend = data_in; m_pdp = dp_in; m_full = 1;
         end
         m_prev = int'(digit_sel);
         e.rdy = (m_full == 0);
      end
      cyc++;
      expq.push_back(e);
   end

   task automatic chk(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (expq.size() == 0) begin
         chk("queue_underflow", 0, 1);
      end else begin
         e = expq.pop_front();
         chk("ready_b4", int'(rdy0), int'(e.rdy));
         chk("ready_b0", int'(rdy1), int'(e.rdy));
         chk("anodes_b4", int'(an0), int'(e.an0));
         chk("anodes_b0", int'(an1), int'(e.an1));
         if (e.cs0) begin
            chk("seg_b4", int'(sg0), int'(e.sg0));
            chk("dp_b4", int'(dp0), int'(e.dp0));
         end
         if (e.cs1) begin
            chk("seg_b0", int'(sg1), int'(e.sg1));
            chk("dp_b0", int'(dp1), int'(e.dp1));
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic frame();
      for (int d = 0; d < 4; d++) begin
         digit_sel = 2'(d);
         tick(16);
      end
   endtask

   initial begin
      int dwell;
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      lz_en = 1'b1;
      frame();

      digit_sel = 2'd0; tick(16);
      digit_sel = 2'd1; tick(5);
      data_in = 16'h1A3F; dp_in = 4'b0100; data_valid = 1'b1; tick(1);
      data_valid = 1'b0; tick(11);
      digit_sel = 2'd2; tick(16);
      digit_sel = 2'd3; tick(16);
      frame();

      data_in = 16'h1111; dp_in = 4'h0; data_valid = 1'b1; tick(1);
      data_in = 16'h2222; tick(3);
      frame();
      frame();
      data_valid = 1'b0;
      frame();

      data_in = 16'h00A0; dp_in = 4'b1000; data_valid = 1'b1; tick(1);
      data_valid = 1'b0;
      frame();
      frame();

      data_in = 16'hBEEF; dp_in = 4'b0011; data_valid = 1'b1; tick(1);
      data_valid = 1'b0;
      digit_sel = 2'd1; tick(2);
      reset = 1'b1; tick(2);
      reset = 1'b0;
      frame();
      frame();

      dwell = 1;
      for (int i = 0; i < 2500; i++) begin
         dwell--;
         if (dwell == 0) begin
            dwell = int'($urandom_range(1, 12));
            if ($urandom_range(0, 7) == 0) digit_sel = 2'($urandom);
            else digit_sel = digit_sel + 2'd1;
         end
         data_valid = ($urandom_range(0, 2) == 0);
         for (int k = 0; k < 4; k++)
            data_in[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         dp_in = 4'($urandom);
         if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
         reset = ($urandom_range(0, 299) == 0);
         tick(1);
      end
      reset = 1'b0;
      data_valid = 1'b0;
      tick(3);
      chk("queue_drained", expq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Display back-end for the 4-digit hex display, directly downstream of the 2-bit scan counter.
- Consumes the counter's digit select and takes a 16-bit value from the system side through a valid/ready handshake.
- Swaps new values in only at frame boundaries, so a frame never mixes old and new digits.
- Drives active-low anodes, segments and decimal point, with an anode-off blanking window after every digit change (anti-ghosting) and optional leading-zero suppression.

Parameters:
- BLANK_CYCLES, 4, clk cycles all anodes are held off after each digit_sel change; 0 disables blanking; legal range 0..255.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- digit_sel, input, 2, current digit index from the scan counter (0 = rightmost).
- data_in, input, 16, hex value to show; digit i = data_in[4i+3:4i].
- dp_in, input, 4, decimal point per digit, 1 = lit; captured together with data_in.
- data_valid, input, 1, data_in/dp_in are valid this cycle.
- data_ready, output, 1, block can accept a value this cycle.
- lz_en, input, 1, leading-zero suppression enable; sampled live, no capture.
- anodes_n, output, 4, digit enables, active-low, one-hot-low or all-high.
- seg_n, output, 7, segments {g,f,e,d,c,b,a}, active-low.
- dp_n, output, 1, decimal point, active-low.

Behaviour:
- Reset is synchronous, active-high, on clk; clock clk. While reset = 1 and on the following edge:
  - anodes_n = 4'hF, seg_n = 7'h7F, dp_n = 1.
  - Active value = 16'h0000, active dp = 4'h0, pending register empty.
  - sel_q = 0, blank counter = 0, data_ready = 0.
- data_ready = ~pend_full & ~reset. The value is combinational from registers.
- Handshake: a transfer occurs on an edge where data_valid & data_ready. data_in/dp_in are copied into the pending register and pend_full is set. data_ready drops the next cycle. A second value is never accepted while pend_full = 1; data_valid may stay high and is simply not consumed.
- sel_q is a register holding the previous digit_sel.
  - Frame boundary: the cycle where sel_q == 3 and digit_sel == 0.
  - Change: the cycle where digit_sel != sel_q.
- At a frame boundary with pend_full = 1, the active value and dp are loaded from pending and pend_full clears, so data_ready = 1 the next cycle. At a boundary with pend_full = 0, nothing changes.
- A transfer landing on the boundary cycle itself (pend_full was 0) fills pending. It is promoted at the next boundary, not the current one.
- Blanking:
  - On a change cycle, the blank counter loads BLANK_CYCLES. Otherwise it decrements if nonzero.
  - The output register drives anodes_n = 4'hF whenever the counter value it loads is nonzero.
  - Result: anodes are off for exactly BLANK_CYCLES cycles starting one cycle after the change.
  - With BLANK_CYCLES = 0, the new anode appears one cycle after the change.
- Output latency: all outputs are registered. Outputs at edge n+1 reflect digit_sel, active value, lz_en and blank state at edge n.
- When not blanking, for digit d = digit_sel:
  - anodes_n = ~(4'b0001 << d).
  - seg_n = hex decode of active nibble d.
  - dp_n = ~active_dp[d].
- Hex decode (seg_n, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero suppression (lz_en = 1):
  - Digit d ≥ 1 is suppressed if nibble d and all higher nibbles are zero. Digit 0 is never suppressed.
  - A suppressed digit with its dp clear gets anodes_n = 4'hF.
  - A suppressed digit with its dp set keeps its anode on, with seg_n = 7'h7F and dp_n = 0.
- digit_sel may jump non-sequentially. Any change triggers blanking; only the 3→0 transition counts as a frame boundary.
- Reset mid-frame or mid-blank: all state returns to reset values on that edge and any pending value is discarded.

Test Plan:
1. Reset held 3 cycles, then released, digit_sel stepping 0..3 every 16 cycles, BLANK_CYCLES = 4 -> during reset anodes_n = F, seg_n = 7F; after release data_ready = 1 and digit 0 shows seg_n = 40 ("0"); lz_en = 1 suppresses digits 1–3 (anodes_n = F in their slots).
2. Send data_in = 16'h1A3F, dp_in = 4'b0100 mid-frame -> data_ready falls the next cycle; display stays old until the 3→0 boundary; next frame shows digit 0 = 0E, digit 1 = 30, digit 2 = 08 with dp_n = 0, digit 3 = 79; data_ready rises one cycle after the boundary.
3. Each digit_sel change -> anodes_n = F for exactly 4 cycles starting one cycle after the change, then the correct one-hot-low anode. With BLANK_CYCLES = 0, there is no all-off gap.
4. Hold data_valid high with 16'h1111 accepted, then 16'h2222 offered while pend_full -> 16'h2222 is not accepted until after the boundary promotes 16'h1111; no value is lost or duplicated.
5. lz_en = 1, data_in = 16'h00A0, dp_in = 4'b1000 -> digit 3: anode on, seg_n = 7F, dp_n = 0; digit 2: anode off; digit 1: seg_n = 08; digit 0: seg_n = 40.
6. Assert reset while blanking with pend_full = 1 -> next cycle anodes_n = F and data_ready = 0; after release, active = 0000 and the pending value is discarded.
